// File: rtl/dg_pkg.sv
// Shared types for the data-generator packet reader: descriptor layout, FSM states
// and the beat formatting helpers.
package dg_pkg;

    localparam int DESC_WIDTH    = 32;
    localparam int DA_WIDTH      = 4;
    localparam int PRIOR_WIDTH   = 3;
    localparam int LEN_WIDTH     = 10;
    localparam int WAIT_WIDTH    = 10;
    localparam int RSVD_WIDTH    = 5;
    localparam int BEAT_WIDTH    = 16;
    localparam int PKT_CNT_WIDTH = 16;

    // Field order is MSB first: [31:27] rsvd, [26:17] wait, [16:7] len, [6:4] prior, [3:0] da.
    typedef struct packed {
        logic [RSVD_WIDTH-1:0]  rsvd;
        logic [WAIT_WIDTH-1:0]  wait_clks;
        logic [LEN_WIDTH-1:0]   len;
        logic [PRIOR_WIDTH-1:0] prior;
        logic [DA_WIDTH-1:0]    da;
    } desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_WAIT,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    function automatic logic [DESC_WIDTH-1:0] hdr_word(
        input logic [3:0]             port_id,
        input logic [DA_WIDTH-1:0]    da,
        input logic [PRIOR_WIDTH-1:0] prior,
        input logic [LEN_WIDTH-1:0]   len
    );
        return {port_id, da, prior, 11'b0, len};
    endfunction

    function automatic logic [DESC_WIDTH-1:0] payload_word(
        input logic [3:0]            port_id,
        input logic [11:0]           pkt_lo,
        input logic [BEAT_WIDTH-1:0] beat
    );
        return {port_id, pkt_lo, beat};
    endfunction

endpackage

// File: rtl/dg_pkt_reader.sv
// Descriptor RAM player: fetches descriptors from address 0, idles the requested number
// of clocks, then emits a header beat plus len payload beats on a valid/ready stream.
module dg_pkt_reader
    import dg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ID         = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_pkt_cnt
);

    localparam logic [3:0]            PORT_ID   = 4'(ID);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                   state_reg, state_next;
    logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
    logic [DA_WIDTH-1:0]      da_reg, da_next;
    logic [PRIOR_WIDTH-1:0]   prior_reg, prior_next;
    logic [LEN_WIDTH-1:0]     len_reg, len_next;
    logic [WAIT_WIDTH-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [BEAT_WIDTH-1:0]    beat_reg, beat_next;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_reg, pkt_cnt_next;

    desc_t ram_desc;
    logic  desc_unused;
    logic  last_beat;

    assign ram_desc    = desc_t'(i_ram_data);
    assign desc_unused = ^ram_desc.rsvd;
    assign last_beat   = (beat_reg == (BEAT_WIDTH'(len_reg) - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            da_reg       <= '0;
            prior_reg    <= '0;
            len_reg      <= '0;
            wait_cnt_reg <= '0;
            beat_reg     <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            da_reg       <= da_next;
            prior_reg    <= prior_next;
            len_reg      <= len_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_reg     <= beat_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        da_next       = da_reg;
        prior_next    = prior_reg;
        len_next      = len_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_next     = beat_reg;
        pkt_cnt_next  = pkt_cnt_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_next   = ST_FETCH;
                    addr_next    = '0;
                    pkt_cnt_next = '0;
                end
            end
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: begin
                da_next    = ram_desc.da;
                prior_next = ram_desc.prior;
                len_next   = ram_desc.len;
                // len==0 marks the end of the descriptor list.
                if (ram_desc.len == '0) begin
                    state_next = ST_DONE;
                end else if (ram_desc.wait_clks == '0) begin
                    state_next = ST_HDR;
                end else begin
                    wait_cnt_next = ram_desc.wait_clks;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 1'b1;
                if (wait_cnt_reg == WAIT_WIDTH'(1)) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (i_ready) begin
                    state_next = ST_DATA;
                    beat_next  = '0;
                end
            end
            ST_DATA: begin
                if (i_ready) begin
                    beat_next = beat_reg + 1'b1;
                    if (last_beat) begin
                        pkt_cnt_next = pkt_cnt_reg + 1'b1;
                        // Stop at the top of the RAM rather than wrapping to address 0.
                        if (addr_reg == LAST_ADDR) begin
                            state_next = ST_DONE;
                        end else begin
                            addr_next  = addr_reg + 1'b1;
                            state_next = ST_FETCH;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers so async reset clears o_valid immediately.
    always_comb begin
        o_data = '0;
        if (state_reg == ST_HDR) begin
            o_data = hdr_word(PORT_ID, da_reg, prior_reg, len_reg);
        end else if (state_reg == ST_DATA) begin
            o_data = payload_word(PORT_ID, pkt_cnt_reg[11:0], beat_reg);
        end
    end

    assign o_ram_en   = (state_reg == ST_FETCH);
    assign o_ram_we   = 1'b0;
    assign o_ram_addr = addr_reg;
    assign o_valid    = (state_reg == ST_HDR) || (state_reg == ST_DATA);
    assign o_sop      = (state_reg == ST_HDR);
    assign o_eop      = (state_reg == ST_DATA) && last_beat;
    assign o_busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign o_done     = (state_reg == ST_DONE);
    assign o_pkt_cnt  = pkt_cnt_reg;

endmodule
